pio_txfifo_regs: RTL and testbench

PIO_TXFIFO_REGS -- requirements
Module: pio_txfifo_regs

---
 rtl/pio_txfifo_pkg.sv | 31 +++
 rtl/pio_txfifo_regs_if.sv | 26 ++
 rtl/pio_sync_fifo.sv | 53 +++++
 rtl/pio_txfifo_regs.sv | 180 ++++++++++++++++++
 tb/tb_pio_txfifo_regs.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_txfifo_pkg.sv
// Shared constants for the PIO TX/RX byte FIFO register block:
// register offsets, CTRL/STATUS bit positions and bus FSM states.
package pio_txfifo_pkg;

  localparam int DEF_FIFO_DEPTH = 16;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_RXDATA = 2'd3;

  localparam int CTRL_TXEN    = 0;
  localparam int CTRL_TXFLUSH = 1;
  localparam int CTRL_RXFLUSH = 2;
  localparam int CTRL_IRQ_TXE = 3;
  localparam int CTRL_IRQ_RXA = 4;

  localparam int ST_TXLVL   = 0;
  localparam int ST_RXLVL   = 16;
  localparam int ST_TXFULL  = 25;
  localparam int ST_TXEMPTY = 26;
  localparam int ST_RXEMPTY = 27;
  localparam int ST_TXOVF   = 28;
  localparam int ST_RXOVF   = 29;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } bus_state_e;

endpackage

// File: rtl/pio_txfifo_regs_if.sv
// PIO register bus: select/strobes, address, byte enables, data
// and the access acknowledge.
interface pio_txfifo_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  pio_cs;
  logic                  pio_wr;
  logic                  pio_rd;
  logic [ADDR_WIDTH-1:0] pio_addr;
  logic [3:0]            pio_be;
  logic [31:0]           pio_datawr;
  logic [31:0]           pio_datard;
  logic                  pio_readyo;

  modport master (
    output pio_cs, pio_wr, pio_rd,
    output pio_addr, pio_be, pio_datawr,
    input  pio_datard, pio_readyo
  );

  modport slave (
    input  pio_cs, pio_wr, pio_rd,
    input  pio_addr, pio_be, pio_datawr,
    output pio_datard, pio_readyo
  );
endinterface

// File: rtl/pio_sync_fifo.sv
// Synchronous byte FIFO; full/empty come from the start-of-cycle
// level, flush wins over push and pop.
module pio_sync_fifo
  import pio_txfifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  input  logic        flush,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/pio_txfifo_regs.sv
// PIO register block with TX/RX byte FIFOs; 2-cycle bus access.
// Define PIO_TXFIFO_IRQ_EN to build the level interrupt logic.
module pio_txfifo_regs
  import pio_txfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       pio_clk,
  input  logic       pio_rst,
  pio_txfifo_regs_if.slave bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  bus_state_e state;
  bus_state_e nstate;

  logic        req, ack, wr_ack;
  logic [1:0]  off;
  logic        sel_ctrl, sel_stat;
  logic        sel_txd, sel_rxd;
  logic        txen, ie_txe, ie_rxa;
  logic        tx_ovf, rx_ovf;
  logic        tx_push, tx_pop, tx_flush;
  logic        rx_pop, rx_flush;
  logic        tx_full, tx_empty;
  logic        rx_full, rx_empty;
  logic [AW:0] tx_level, rx_level;
  logic [7:0]  rx_head;
  logic        wr_ctrl, w1c;
  logic [31:0] status, rd_mux, datard_q;
  logic        unused_ok;

  assign req      = bus.pio_cs & (bus.pio_wr | bus.pio_rd);
  assign ack      = (state == S_ACK);
  assign wr_ack   = ack & bus.pio_cs & bus.pio_wr;
  assign off      = bus.pio_addr[3:2];
  assign sel_ctrl = (off == OFF_CTRL);
  assign sel_stat = (off == OFF_STATUS);
  assign sel_txd  = (off == OFF_TXDATA);
  assign sel_rxd  = (off == OFF_RXDATA);

  always_ff @(posedge pio_clk) begin
    if (pio_rst) state <= S_IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (req) nstate = S_ACK;
      S_ACK:  nstate = S_IDLE;
    endcase
  end

  assign wr_ctrl  = wr_ack & sel_ctrl & bus.pio_be[0];
  assign w1c      = wr_ack & sel_stat & bus.pio_be[3];
  assign tx_push  = wr_ack & sel_txd & bus.pio_be[0];
  assign tx_flush = wr_ctrl & bus.pio_datawr[CTRL_TXFLUSH];
  assign rx_flush = wr_ctrl & bus.pio_datawr[CTRL_RXFLUSH];
  assign rx_pop   = ack & bus.pio_cs & bus.pio_rd & sel_rxd;
  assign tx_valid = txen & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  pio_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk   (pio_clk),
    .rst   (pio_rst),
    .push  (tx_push),
    .din   (bus.pio_datawr[7:0]),
    .pop   (tx_pop),
    .flush (tx_flush),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  pio_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk   (pio_clk),
    .rst   (pio_rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .flush (rx_flush),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_ff @(posedge pio_clk) begin
    if (pio_rst)      txen <= 1'b0;
    else if (wr_ctrl) txen <= bus.pio_datawr[CTRL_TXEN];
  end

`ifdef PIO_TXFIFO_IRQ_EN
  always_ff @(posedge pio_clk) begin
    if (pio_rst) begin
      ie_txe <= 1'b0;
      ie_rxa <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie_txe <= bus.pio_datawr[CTRL_IRQ_TXE];
        ie_rxa <= bus.pio_datawr[CTRL_IRQ_RXA];
      end
      irq <= (ie_txe & tx_empty) | (ie_rxa & ~rx_empty);
    end
  end
`else
  assign ie_txe = 1'b0;
  assign ie_rxa = 1'b0;
  assign irq    = 1'b0;
`endif

  // a same-cycle overflow beats the W1C clear
  always_ff @(posedge pio_clk) begin
    if (pio_rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_push & tx_full)
        tx_ovf <= 1'b1;
      else if (w1c & bus.pio_datawr[ST_TXOVF])
        tx_ovf <= 1'b0;
      if (rx_valid & rx_full)
        rx_ovf <= 1'b1;
      else if (w1c & bus.pio_datawr[ST_RXOVF])
        rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[ST_TXLVL +: 9] = 9'(tx_level);
    status[ST_RXLVL +: 9] = 9'(rx_level);
    status[ST_TXFULL]     = tx_full;
    status[ST_TXEMPTY]    = tx_empty;
    status[ST_RXEMPTY]    = rx_empty;
    status[ST_TXOVF]      = tx_ovf;
    status[ST_RXOVF]      = rx_ovf;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: begin
        rd_mux[CTRL_TXEN]    = txen;
        rd_mux[CTRL_IRQ_TXE] = ie_txe;
        rd_mux[CTRL_IRQ_RXA] = ie_rxa;
      end
      sel_stat: rd_mux = status;
      sel_rxd:  rd_mux = {23'b0, ~rx_empty,
                          rx_empty ? 8'h00 : rx_head};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge pio_clk) begin
    if (pio_rst)
      datard_q <= '0;
    else if (!ack && req && bus.pio_rd)
      datard_q <= rd_mux;
    else
      datard_q <= '0;
  end

  assign bus.pio_datard = datard_q;
  assign bus.pio_readyo = ack;

  assign unused_ok = ^{bus.pio_addr[ADDR_WIDTH-1:4],
                       bus.pio_addr[1:0], bus.pio_be[2:1],
                       bus.pio_datawr};
endmodule

// File: tb/tb_pio_txfifo_regs.sv
// Scoreboard bench for pio_txfifo_regs: reads and TX bytes are
// queued at issue time and checked by independent monitors.
module tb_pio_txfifo_regs;
  import pio_txfifo_pkg::*;

`ifdef PIO_TXFIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       pio_clk;
  logic       pio_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq;

  pio_txfifo_regs_if #(.ADDR_WIDTH(8)) bus ();

  pio_txfifo_regs #(.ADDR_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .pio_clk  (pio_clk),
    .pio_rst  (pio_rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  exp_t       rdq[$];
  logic [7:0] txq[$];

  initial pio_clk = 1'b0;
  always #5 pio_clk = ~pio_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge pio_clk) begin
    if (bus.pio_readyo === 1'b1 && bus.pio_rd === 1'b1) begin
      if (rdq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got 0x%08h want none",
                 bus.pio_datard);
      end else begin
        exp_t e;
        e = rdq.pop_front();
        chk(e.nm, bus.pio_datard, e.v);
      end
    end
  end

  always @(negedge pio_clk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (txq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got 0x%02h want none",
                 tx_data);
      end else begin
        chk("tx_byte", {24'b0, tx_data}, {24'b0, txq.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pio_clk);
      #1;
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a,
                        input logic [3:0] be,
                        input logic [31:0] d,
                        input logic pulse, output int lat);
    bus.pio_cs     = 1'b1;
    bus.pio_wr     = w;
    bus.pio_rd     = ~w;
    bus.pio_addr   = a;
    bus.pio_be     = be;
    bus.pio_datawr = d;
    lat = 1;
    do begin
      @(posedge pio_clk);
      #1;
      lat++;
    end while (!bus.pio_readyo && lat < 8);
    if (!bus.pio_readyo) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no readyo want readyo a=%h", a);
    end
    if (pulse) tx_ready = 1'b1;
    @(posedge pio_clk);
    #1;
    bus.pio_cs = 1'b0;
    bus.pio_wr = 1'b0;
    bus.pio_rd = 1'b0;
    if (pulse) tx_ready = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    int l;
    access(1'b1, a, be, d, 1'b0, l);
  endtask

  task automatic rd(input string nm, input logic [7:0] a,
                    input logic [31:0] v);
    int l;
    exp_t e;
    e.nm = nm;
    e.v  = v;
    rdq.push_back(e);
    access(1'b0, a, 4'hf, 32'h0, 1'b0, l);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_low(input string nm, input int n);
    for (int i = 0; i < n && tx_valid; i++) idle(1);
    chk(nm, {31'b0, tx_valid}, 32'h0);
  endtask

  initial begin
    int lat;
    pio_rst        = 1'b1;
    bus.pio_cs     = 1'b0;
    bus.pio_wr     = 1'b0;
    bus.pio_rd     = 1'b0;
    bus.pio_addr   = '0;
    bus.pio_be     = '0;
    bus.pio_datawr = '0;
    tx_ready       = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = '0;
    idle(3);
    chk("rst_readyo", {31'b0, bus.pio_readyo}, 32'h0);
    chk("rst_datard", bus.pio_datard, 32'h0);
    chk("rst_txvalid", {31'b0, tx_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    pio_rst = 1'b0;
    idle(1);
    rd("rst_status", 8'h04, 32'h0C00_0000);
    rd("rst_ctrl", 8'h00, 32'h0);

    // single byte through with TXEN and tx_ready
    tx_ready = 1'b1;
    wr(8'h00, 4'h1, 32'h1);
    txq.push_back(8'h5A);
    access(1'b1, 8'h08, 4'h1, 32'h5A, 1'b0, lat);
    chk("wr_latency", lat, 32'd2);
    chk("tx_valid_up", {31'b0, tx_valid}, 32'h1);
    chk("tx_head", {24'b0, tx_data}, 32'h5A);
    wait_tx_low("tx_drain1", 20);
    rd("tx_empty1", 8'h04, 32'h0C00_0000);

    // fill past full with TX disabled, then W1C
    wr(8'h00, 4'h1, 32'h0);
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(8'h08, 4'h1, 32'(i));
      if (i < 16) txq.push_back(8'(i));
    end
    rd("tx_full", 8'h04, 32'h1A00_0010);
    wr(8'h04, 4'h8, 32'h1000_0000);
    rd("txovf_w1c", 8'h04, 32'h0A00_0010);

    // pop and push on a full FIFO in the same cycle
    wr(8'h00, 4'h1, 32'h1);
    chk("full_valid", {31'b0, tx_valid}, 32'h1);
    chk("full_head", {24'b0, tx_data}, 32'h0);
    access(1'b1, 8'h08, 4'h1, 32'hEE, 1'b1, lat);
    rd("push_drop", 8'h04, 32'h1800_000F);
    wr(8'h04, 4'h8, 32'h1000_0000);
    tx_ready = 1'b1;
    wait_tx_low("tx_drain2", 40);
    tx_ready = 1'b0;
    rd("tx_empty2", 8'h04, 32'h0C00_0000);

    // CTRL flush bits self-clear, be[0] gating, TXDATA reads 0
    wr(8'h00, 4'h1, 32'h3);
    rd("ctrl_selfclr", 8'h00, 32'h1);
    wr(8'h00, 4'h2, 32'h0);
    rd("ctrl_be0", 8'h00, 32'h1);
    rd("txdata_rd", 8'h08, 32'h0);
    wr(8'h00, 4'h1, 32'h0);

    // RX pops and empty read
    rx_push(8'h11);
    rx_push(8'h22);
    rd("rx_lvl2", 8'h04, 32'h0402_0000);
    rd("rx_pop1", 8'h0C, 32'h111);
    rd("rx_pop2", 8'h0C, 32'h122);
    rd("rx_empty_rd", 8'h0C, 32'h0);
    rd("rx_no_uflow", 8'h04, 32'h0C00_0000);

    // RX overflow, flush, W1C gating on be[3]
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    rd("rx_full", 8'h04, 32'h2410_0000);
    wr(8'h00, 4'h1, 32'h4);
    rd("rx_flush", 8'h04, 32'h2C00_0000);
    wr(8'h04, 4'h7, 32'h2000_0000);
    rd("w1c_be3", 8'h04, 32'h2C00_0000);
    wr(8'h04, 4'h8, 32'h2000_0000);
    rd("rxovf_w1c", 8'h04, 32'h0C00_0000);

    // interrupt enables
    rx_push(8'h33);
    wr(8'h00, 4'h1, 32'h18);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_lat", {31'b0, irq}, {31'b0, IRQ_ON});
    rd("ctrl_irq", 8'h00, IRQ_ON ? 32'h18 : 32'h0);
    wr(8'h00, 4'h1, 32'h14);
    idle(2);
    chk("irq_rx_gone", {31'b0, irq}, 32'h0);
    rd("rxflush_lvl", 8'h04, 32'h0C00_0000);

    // reset in the ACK cycle of a TXDATA write
    bus.pio_cs     = 1'b1;
    bus.pio_wr     = 1'b1;
    bus.pio_addr   = 8'h08;
    bus.pio_be     = 4'h1;
    bus.pio_datawr = 32'h77;
    idle(1);
    chk("ack_pre_rst", {31'b0, bus.pio_readyo}, 32'h1);
    pio_rst = 1'b1;
    idle(1);
    chk("rst_ack_rdy", {31'b0, bus.pio_readyo}, 32'h0);
    chk("rst_ack_txv", {31'b0, tx_valid}, 32'h0);
    chk("rst_ack_irq", {31'b0, irq}, 32'h0);
    chk("rst_ack_drd", bus.pio_datard, 32'h0);
    bus.pio_cs = 1'b0;
    bus.pio_wr = 1'b0;
    pio_rst    = 1'b0;
    idle(1);
    rd("rst_no_push", 8'h04, 32'h0C00_0000);
    rd("rst_ctrl_clr", 8'h00, 32'h0);

    idle(2);
    chk("rdq_drained", 32'(rdq.size()), 32'h0);
    chk("txq_drained", 32'(txq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
